// File: rtl/bk_pkg.sv
// bk_pkg: shared widths, operand/sum types and bus helpers for the Brent-Kung adder stage
package bk_pkg;
  localparam int BK_W = 12;
  typedef logic [BK_W-1:0] bk_opnd_t;
  typedef logic [BK_W:0] bk_sum_t;
  function automatic logic [2*BK_W-1:0] bk_interleave(input bk_opnd_t a, input bk_opnd_t b);
    logic [2*BK_W-1:0] r;
    for (int i = 0; i < BK_W; i++) begin
      r[2*i] = a[i];
      r[2*i+1] = b[i];
    end
    return r;
  endfunction
  function automatic bk_sum_t bk_ref_sum(input bk_opnd_t a, input bk_opnd_t b);
    return {1'b0, a} + {1'b0, b};
  endfunction
endpackage

// File: rtl/bk_result_fifo.sv
// bk_result_fifo: circular result buffer with registered storage and combinational head read
module bk_result_fifo #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic pop_e;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign pop_e = pop & !empty;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_e) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop_e);
    end
  end
endmodule

// File: rtl/bk_operand_pipe.sv
// bk_operand_pipe: operand register + result FIFO around bk_add; BK_CARRY_CNT_EN adds a carry-out counter
module bk_operand_pipe
  import bk_pkg::*;
#(
  parameter int W = BK_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [W-1:0]                    in_a,
  input  logic [W-1:0]                    in_b,
  output logic [2*W-1:0]                  add_in,
  input  logic [W:0]                      add_out,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [W:0]                      out_sum,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_cnt,
  output logic [15:0]                     carry_cnt
);
  logic s1_vld, push, pop, full, empty;
  logic [W-1:0] s1_a, s1_b;
  assign out_valid = !empty;
  assign pop = out_valid & out_ready;
  assign push = s1_vld & (!full | pop);
  assign in_ready = !s1_vld | push;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s1_a <= '0;
      s1_b <= '0;
    end else if (in_valid & in_ready) begin
      s1_vld <= 1'b1;
      s1_a <= in_a;
      s1_b <= in_b;
    end else if (push) s1_vld <= 1'b0;
  end
  // bus is gated by s1_vld so the adder sees zero while the stage is idle
  for (genvar i = 0; i < W; i++) begin : g_il
    assign add_in[2*i] = s1_vld & s1_a[i];
    assign add_in[2*i+1] = s1_vld & s1_b[i];
  end
  bk_result_fifo #(.WIDTH(W+1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .din(add_out),
    .dout(out_sum), .full(full), .empty(empty), .count(fifo_cnt)
  );
`ifdef BK_CARRY_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) carry_cnt <= '0;
    else if (push & add_out[W] & (carry_cnt != 16'hFFFF)) carry_cnt <= carry_cnt + 16'd1;
  end
`else
  assign carry_cnt = 16'h0;
`endif
endmodule

// File: tb/tb_bk_operand_pipe.sv
// tb_bk_operand_pipe: scoreboard bench with a behavioural adder behind add_in/add_out
module tb_bk_operand_pipe;
  import bk_pkg::*;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid;
  logic [11:0] in_a = '0, in_b = '0, dec_a, dec_b;
  logic [23:0] add_in;
  logic [12:0] add_out, out_sum;
  logic [2:0] fifo_cnt;
  logic [15:0] carry_cnt;
  int n_cmp = 0, n_err = 0;
  bk_sum_t sb[$];
  always #5 clk = ~clk;
  bk_operand_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .add_in(add_in), .add_out(add_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .fifo_cnt(fifo_cnt), .carry_cnt(carry_cnt)
  );
  always_comb begin
    dec_a = '0;
    dec_b = '0;
    for (int i = 0; i < 12; i++) begin
      dec_a[i] = add_in[2*i];
      dec_b[i] = add_in[2*i+1];
    end
  end
  assign add_out = {1'b0, dec_a} + {1'b0, dec_b};
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [11:0] a, input logic [11:0] b);
    int n = 0;
    logic acc;
    in_valid = 1;
    in_a = a;
    in_b = b;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 50);
    chk("accept", 32'(acc), 1);
  endtask
  task automatic drain();
    int n = 0;
    in_valid = 0;
    while ((sb.size() != 0 || out_valid) && n < 100) begin
      step();
      n++;
    end
    chk("drain", 32'(sb.size()), 0);
  endtask
  always @(negedge clk) if (rst_n) begin
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $error("FAIL extra_out observed=%h expected=none", out_sum);
      end else chk("sum", 32'(out_sum), 32'(sb.pop_front()));
    end
    if (in_valid && in_ready) sb.push_back(bk_ref_sum(in_a, in_b));
  end
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic rdy_ok, gap_ok, cnt_ok;
    logic [11:0] pa[6], pb[6];
    logic [12:0] held;
    int exp_carry;
    #3;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_sum", 32'(out_sum), 0);
    chk("rst_add_in", 32'(add_in), 0);
    chk("rst_fifo_cnt", 32'(fifo_cnt), 0);
    step();
    rst_n = 1;
    step();
    // single transaction: FFF + 001
    out_ready = 1;
    send(12'hFFF, 12'h001);
    in_valid = 0;
    chk("single_add_in", 32'(add_in), 32'h555557);
    chk("single_valid_early", 32'(out_valid), 0);
    step();
    chk("single_valid", 32'(out_valid), 1);
    chk("single_sum", 32'(out_sum), 32'h1000);
    chk("single_add_in_idle", 32'(add_in), 0);
    drain();
    // streaming
    rdy_ok = 1;
    gap_ok = 1;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1;
      in_a = 12'($urandom);
      in_b = 12'($urandom);
      @(negedge clk);
      if (!in_ready) rdy_ok = 0;
      if (i >= 2 && !out_valid) gap_ok = 0;
      step();
    end
    drain();
    chk("stream_in_ready", 32'(rdy_ok), 1);
    chk("stream_no_gap", 32'(gap_ok), 1);
    // backpressure
    out_ready = 0;
    for (int i = 0; i < 6; i++) begin
      pa[i] = 12'($urandom);
      pb[i] = 12'($urandom);
    end
    for (int i = 0; i < 5; i++) send(pa[i], pb[i]);
    in_a = pa[5];
    in_b = pb[5];
    step();
    step();
    chk("bp_fifo_cnt", 32'(fifo_cnt), 4);
    chk("bp_in_ready", 32'(in_ready), 0);
    chk("bp_s1_hold", 32'(add_in), 32'(bk_interleave(pa[4], pb[4])));
    held = out_sum;
    step();
    chk("bp_sum_stable", 32'(out_sum), 32'(held));
    chk("bp_head", 32'(out_sum), 32'(bk_ref_sum(pa[0], pb[0])));
    chk("bp_valid_stable", 32'(out_valid), 1);
    out_ready = 1;
    send(pa[5], pb[5]);
    drain();
    // full FIFO with simultaneous push and pop
    out_ready = 0;
    for (int i = 0; i < 5; i++) send(12'($urandom), 12'($urandom));
    out_ready = 1;
    cnt_ok = 1;
    for (int i = 0; i < 20; i++) begin
      in_a = 12'($urandom);
      in_b = 12'($urandom);
      @(negedge clk);
      if (fifo_cnt != 3'd4 || !in_ready) cnt_ok = 0;
      step();
    end
    drain();
    chk("full_pushpop", 32'(cnt_ok), 1);
    // async reset with three results queued
    out_ready = 0;
    for (int i = 0; i < 3; i++) send(12'h800, 12'h800);
    in_valid = 0;
    step();
    chk("pre_rst_cnt", 32'(fifo_cnt), 3);
    #3;
    rst_n = 0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 0);
    chk("arst_fifo_cnt", 32'(fifo_cnt), 0);
    chk("arst_in_ready", 32'(in_ready), 1);
    chk("arst_carry_cnt", 32'(carry_cnt), 0);
    chk("arst_out_sum", 32'(out_sum), 0);
    sb.delete();
    step();
    rst_n = 1;
    step();
    // carry counter
    out_ready = 1;
    send(12'h800, 12'h800);
    send(12'h800, 12'h7FF);
    send(12'h800, 12'h800);
    send(12'h123, 12'h456);
    send(12'h800, 12'h800);
    drain();
`ifdef BK_CARRY_CNT_EN
    exp_carry = 3;
`else
    exp_carry = 0;
`endif
    chk("carry_cnt", 32'(carry_cnt), 32'(exp_carry));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
